// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one multiplier between four requesters; result held until acked.
// Optional overflow flag output enabled by defining MUL_ARBITER_OVF_EN.
module mul_arbiter #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned NREQ      = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NREQ-1:0]           req_i,
    input  logic [NREQ*DATAWIDTH-1:0] a_i,
    input  logic [NREQ*DATAWIDTH-1:0] b_i,
    output logic [NREQ-1:0]           gnt_o,
    output logic                      busy_o,
    output logic [DATAWIDTH-1:0]      result_o,
    output logic [1:0]                result_id_o,
    output logic                      valid_o,
`ifdef MUL_ARBITER_OVF_EN
    output logic                      ovf_o,
`endif
    input  logic                      ack_i
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [DATAWIDTH-1:0] op_a_q, op_a_d;
    logic [DATAWIDTH-1:0] op_b_q, op_b_d;
    logic [NREQ-1:0]      gnt_q, gnt_d;
    logic [DATAWIDTH-1:0] result_q, result_d;
    logic [1:0]           result_id_q, result_id_d;
    logic                 valid_q, valid_d;

    logic [DATAWIDTH-1:0] prod;
    logic                 win_found;
    logic [1:0]           win_idx;
    logic [1:0]           cand;

`ifdef MUL_ARBITER_OVF_EN
    logic                     ovf_q, ovf_d;
    logic [2*DATAWIDTH-1:0]   prod_wide;

    assign prod_wide = {{DATAWIDTH{1'b0}}, op_a_q} * {{DATAWIDTH{1'b0}}, op_b_q};
    assign prod      = prod_wide[DATAWIDTH-1:0];
`else
    assign prod = op_a_q * op_b_q;
`endif

    // First requesting index at or after the priority pointer, wrapping mod 4.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = ptr_q + 2'(i);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        gnt_d       = '0;
        result_d    = result_q;
        result_id_d = result_id_q;
        valid_d     = valid_q;
`ifdef MUL_ARBITER_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    op_a_d         = a_i[win_idx*DATAWIDTH +: DATAWIDTH];
                    op_b_d         = b_i[win_idx*DATAWIDTH +: DATAWIDTH];
                    gnt_d[win_idx] = 1'b1;
                    result_id_d    = win_idx;
                    state_d        = StBusy;
                end
            end
            StBusy: begin
                result_d = prod;
                valid_d  = 1'b1;
`ifdef MUL_ARBITER_OVF_EN
                ovf_d    = |prod_wide[2*DATAWIDTH-1:DATAWIDTH];
`endif
                state_d  = StDone;
            end
            StDone: begin
                if (ack_i) begin
                    valid_d = 1'b0;
                    ptr_d   = result_id_q + 2'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            ptr_q       <= 2'd0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            gnt_q       <= '0;
            result_q    <= '0;
            result_id_q <= 2'd0;
            valid_q     <= 1'b0;
`ifdef MUL_ARBITER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            gnt_q       <= gnt_d;
            result_q    <= result_d;
            result_id_q <= result_id_d;
            valid_q     <= valid_d;
`ifdef MUL_ARBITER_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign gnt_o       = gnt_q;
    assign busy_o      = (state_q != StIdle);
    assign result_o    = result_q;
    assign result_id_o = result_id_q;
    assign valid_o     = valid_q;
`ifdef MUL_ARBITER_OVF_EN
    assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: randomized stimulus against a behavioural arbiter model.
module tb_mul_arbiter;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req;
    logic [4*DW-1:0] a, b;
    logic          ack;
    logic [3:0]    gnt;
    logic          busy;
    logic [DW-1:0] result;
    logic [1:0]    result_id;
    logic          valid;
`ifdef MUL_ARBITER_OVF_EN
    logic          ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int ptr_m    = 0;

    mul_arbiter #(.DATAWIDTH(DW), .NREQ(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .a_i         (a),
        .b_i         (b),
        .gnt_o       (gnt),
        .busy_o      (busy),
        .result_o    (result),
        .result_id_o (result_id),
        .valid_o     (valid),
`ifdef MUL_ARBITER_OVF_EN
        .ovf_o       (ovf),
`endif
        .ack_i       (ack)
    );

    always #5 clk = ~clk;

    // Reference: first requester at or after the pointer, wrapping.
    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] mul_ref(input logic [DW-1:0] x, input logic [DW-1:0] y);
        int unsigned full;
        full = int'(x) * int'(y);
        return DW'(full % 256);
    endfunction

    function automatic logic ovf_ref(input logic [DW-1:0] x, input logic [DW-1:0] y);
        return (int'(x) * int'(y)) > 255;
    endfunction

    // Stimulus helper: waits (bounded) for a grant pulse, sampling on falling edges.
    task automatic wait_grant(output logic [3:0] g);
        bit seen;
        g = 4'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (gnt !== 4'b0) begin
                g = gnt;
                seen = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = 4'b0; a = '0; b = '0; ack = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({gnt, valid, busy, result, result_id} !== 16'b0)
            $display("FAIL reset_state: got %h, want 0", {gnt, valid, busy, result, result_id});
        else n_pass++;
        rst_n = 1'b1;
        ptr_m = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({gnt, valid, busy, result} !== 14'b0)
                $display("FAIL idle_after_reset[%0d]: got %h, want 0", i, {gnt, valid, busy, result});
            else n_pass++;
        end
    endtask

    task automatic test_single;
        logic [3:0] g, eg;
        a[2*DW +: DW] = 8'd12; b[2*DW +: DW] = 8'd10;
        req = 4'b0100; ack = 1'b1;
        eg = 4'b0001 << pick(req, ptr_m);
        wait_grant(g);
        n_checks++;
        if (g !== eg) $display("FAIL single_gnt: got %b, want %b", g, eg);
        else n_pass++;
        req = 4'b0;
        @(negedge clk);
        n_checks++;
        if ({gnt, valid, result_id, result} !== {4'b0, 1'b1, 2'd2, mul_ref(8'd12, 8'd10)})
            $display("FAIL single_result: got gnt=%b v=%b id=%0d r=%0d, want gnt=0 v=1 id=2 r=120",
                     gnt, valid, result_id, result);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({valid, busy} !== 2'b00) $display("FAIL single_idle: got v/busy=%b, want 00", {valid, busy});
        else n_pass++;
        ptr_m = 3;
    endtask

    task automatic test_truncation;
        logic [DW-1:0] xs [2];
        logic [DW-1:0] ys [2];
        logic [3:0] g;
        xs[0] = 8'd20; ys[0] = 8'd20; xs[1] = 8'd15; ys[1] = 8'd17;
        ack = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a[DW-1:0] = xs[k]; b[DW-1:0] = ys[k]; req = 4'b0001;
            wait_grant(g);
            req = 4'b0;
            @(negedge clk);
            n_checks++;
            if ({valid, result_id, result} !== {1'b1, 2'd0, mul_ref(xs[k], ys[k])})
                $display("FAIL trunc_result[%0d]: got v=%b id=%0d r=%0d, want r=%0d",
                         k, valid, result_id, result, mul_ref(xs[k], ys[k]));
            else n_pass++;
`ifdef MUL_ARBITER_OVF_EN
            n_checks++;
            if (ovf !== ovf_ref(xs[k], ys[k]))
                $display("FAIL trunc_ovf[%0d]: got %b, want %b", k, ovf, ovf_ref(xs[k], ys[k]));
            else n_pass++;
`endif
            @(negedge clk);
        end
        ptr_m = 1;
    endtask

    task automatic test_round_robin;
        logic [3:0] g, eg;
        logic [DW-1:0] ea, eb;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        for (int i = 0; i < 4; i++) begin
            a[i*DW +: DW] = 8'($urandom_range(1, 255));
            b[i*DW +: DW] = 8'($urandom_range(1, 255));
        end
        req = 4'b1111; ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            eg = 4'b0001 << (k % 4);
            ea = a[(k % 4)*DW +: DW]; eb = b[(k % 4)*DW +: DW];
            wait_grant(g);
            n_checks++;
            if (g !== eg) $display("FAIL rr_gnt[%0d]: got %b, want %b", k, g, eg);
            else n_pass++;
            if (k == 4) req = 4'b0;
            @(negedge clk);
            n_checks++;
            if ({valid, result_id, result} !== {1'b1, 2'(k % 4), mul_ref(ea, eb)})
                $display("FAIL rr_result[%0d]: got id=%0d r=%0d, want id=%0d r=%0d",
                         k, result_id, result, k % 4, mul_ref(ea, eb));
            else n_pass++;
            ptr_m = (k % 4 + 1) % 4;
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic [3:0] g, eg;
        logic [DW-1:0] ea, eb, er;
        int w;
        req = 4'b0011; ack = 1'b0;
        a = {$urandom}; b = {$urandom};
        w = pick(req, ptr_m);
        eg = 4'b0001 << w;
        ea = a[w*DW +: DW]; eb = b[w*DW +: DW]; er = mul_ref(ea, eb);
        wait_grant(g);
        n_checks++;
        if (g !== eg) $display("FAIL bp_gnt: got %b, want %b", g, eg);
        else n_pass++;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            a = {$urandom}; b = {$urandom};
            @(negedge clk);
            n_checks++;
            if ({gnt, valid, result_id, result} !== {4'b0, 1'b1, 2'(w), er})
                $display("FAIL bp_hold[%0d]: got gnt=%b v=%b id=%0d r=%0d, want 0/1/%0d/%0d",
                         i, gnt, valid, result_id, result, w, er);
            else n_pass++;
        end
        ptr_m = (w + 1) % 4;
        w = pick(req, ptr_m);
        eg = 4'b0001 << w;
        ea = a[w*DW +: DW]; eb = b[w*DW +: DW]; er = mul_ref(ea, eb);
        ack = 1'b1;
        wait_grant(g);
        n_checks++;
        if (g !== eg) $display("FAIL bp_next_gnt: got %b, want %b", g, eg);
        else n_pass++;
        req = 4'b0;
        @(negedge clk);
        n_checks++;
        if ({valid, result_id, result} !== {1'b1, 2'(w), er})
            $display("FAIL bp_next_result: got id=%0d r=%0d, want id=%0d r=%0d", result_id, result, w, er);
        else n_pass++;
        ptr_m = (w + 1) % 4;
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [3:0] g, eg, r;
        logic [DW-1:0] ea, eb, er;
        int w, d;
        for (int it = 0; it < 30; it++) begin
            r = 4'($urandom_range(0, 15));
            a = {$urandom}; b = {$urandom};
            req = r; ack = 1'($urandom_range(0, 1));
            if (r == 4'b0) begin
                @(negedge clk);
                n_checks++;
                if ({gnt, busy, valid} !== 6'b0)
                    $display("FAIL rnd_idle[%0d]: got %b, want 0", it, {gnt, busy, valid});
                else n_pass++;
                continue;
            end
            w = pick(r, ptr_m);
            eg = 4'b0001 << w;
            ea = a[w*DW +: DW]; eb = b[w*DW +: DW]; er = mul_ref(ea, eb);
            wait_grant(g);
            n_checks++;
            if (g !== eg) $display("FAIL rnd_gnt[%0d]: got %b, want %b", it, g, eg);
            else n_pass++;
            req = 4'($urandom_range(0, 15)); a = {$urandom}; b = {$urandom}; ack = 1'b0;
            @(negedge clk);
            d = $urandom_range(0, 3);
            for (int k = 0; k <= d; k++) begin
                n_checks++;
                if ({valid, result_id, result} !== {1'b1, 2'(w), er})
                    $display("FAIL rnd_result[%0d.%0d]: got v=%b id=%0d r=%0d, want id=%0d r=%0d",
                             it, k, valid, result_id, result, w, er);
                else n_pass++;
                if (k == d) ack = 1'b1;
                @(negedge clk);
            end
            n_checks++;
            if ({valid, busy} !== 2'b00)
                $display("FAIL rnd_consumed[%0d]: got v/busy=%b, want 00", it, {valid, busy});
            else n_pass++;
            ack = 1'b0;
            ptr_m = (w + 1) % 4;
        end
        req = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        logic [3:0] g;
        logic [DW-1:0] ea, eb;
        req = 4'b1000; ack = 1'b0;
        a = {$urandom}; b = {$urandom};
        wait_grant(g);
        req = 4'b0;
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b1) $display("FAIL ar_done: got valid=%b, want 1", valid);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({valid, busy, gnt, result} !== 14'b0)
            $display("FAIL ar_async_drop: got %h, want 0", {valid, busy, gnt, result});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        req = 4'b1111; ack = 1'b1;
        ea = a[DW-1:0]; eb = b[DW-1:0];
        wait_grant(g);
        n_checks++;
        if (g !== 4'b0001) $display("FAIL ar_first_gnt: got %b, want 0001", g);
        else n_pass++;
        req = 4'b0;
        @(negedge clk);
        n_checks++;
        if ({valid, result_id, result} !== {1'b1, 2'd0, mul_ref(ea, eb)})
            $display("FAIL ar_result: got id=%0d r=%0d, want id=0 r=%0d", result_id, result, mul_ref(ea, eb));
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_truncation();
        test_round_robin();
        test_backpressure();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one combinational MUL instance (DATAWIDTH-wide operands, product truncated to DATAWIDTH) between 4 requesters.
- Round-robin arbitration; the winner's operands are latched into an operand register and the product is registered.
- The result is held with the winner's ID until the consumer acknowledges it.
- Sits between the scheduled datapath's operation sources and the single shared multiplier resource.

Parameters:
- DATAWIDTH, 8, operand and result width; passed to the internal MUL instance.
- NREQ, 4, number of requesters; fixed at 4; ID width is 2.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-low reset.
- Req  input  4  per-requester request level; bit i = requester i.
- A  input  4*DATAWIDTH  operand a; slice i = A[i*DATAWIDTH +: DATAWIDTH].
- B  input  4*DATAWIDTH  operand b; same slicing as A.
- Gnt  output  4  one-hot, one-cycle pulse; operands of that requester were latched.
- Busy  output  1  high in BUSY or DONE state.
- Result  output  DATAWIDTH  registered product, (a*b) mod 2^DATAWIDTH.
- ResultId  output  2  index of the requester that owns Result.
- Valid  output  1  Result/ResultId valid.
- Ack  input  1  consumer accepts the result; meaningful only while Valid=1.

Behaviour:
- Reset (Rst=0, asynchronous) clears all of the following:
  - state=IDLE; Gnt=0; Busy=0; Valid=0; Result=0; ResultId=0.
  - operand regs=0; priority pointer Ptr=0.
- The FSM has 3 states, all registered: IDLE, BUSY, DONE.
- IDLE:
  - If Req!=0 at a rising edge, the winner is the first set bit scanning Ptr, Ptr+1, ... mod 4.
  - On that edge: latch A/B slices of the winner; Gnt<=onehot(winner); ResultId<=winner; go to BUSY.
  - If Req==0, stay in IDLE with Gnt=0.
- BUSY:
  - Gnt<=0.
  - Result<=MUL(opA,opB); Valid<=1; go to DONE.
- DONE:
  - Hold Result, ResultId and Valid stable while Ack=0.
  - On an edge with Ack=1: Valid<=0; Ptr<=ResultId+1 (mod 4); go to IDLE.
- Latency:
  - Request sampled at edge N gives the Gnt pulse in cycle N..N+1.
  - Valid=1 from edge N+1.
  - Minimum request-to-request spacing is 3 cycles (grant, compute, ack with immediate Ack).
- Requesters:
  - A requester must hold Req and its operands until it sees its Gnt bit. After Gnt it may drop Req.
  - A Req still high after Gnt is treated as a new request.
  - Req and operand changes during BUSY/DONE are ignored; operands are already latched.
- Fairness: after requester i is served, i has the lowest priority. With all 4 requesting continuously, service order is 0,1,2,3,0,...
- Boundary conditions:
  - Ack while Valid=0: ignored.
  - Ack held high permanently: result is consumed in its first DONE cycle.
  - Ptr wraps 3→0.
  - Simultaneous Req deassert on the grant edge: the grant still completes (the sample was taken).
  - Reset mid-operation: in-flight result discarded, Valid drops immediately (async), Ptr returns to 0.
- Arithmetic: unsigned; the product is truncated to the low DATAWIDTH bits, identical to the standalone MUL.

Optional Feature:
- Macro MUL_ARBITER_OVF_EN.
- When defined:
  - Adds output port Ovf (1 bit).
  - The full 2*DATAWIDTH product is computed internally.
  - Ovf is registered alongside Result, =1 iff the upper DATAWIDTH bits are nonzero.
  - Ovf is held with Valid and reset to 0.
- When undefined: no Ovf port, no wide product logic; behaviour otherwise identical.

Test Plan:
- Reset then idle:
  - Stimulus: Rst=0 for 2 cycles, release, Req=0 for 5 cycles.
  - Required: Gnt=0, Valid=0, Busy=0, Result=0 throughout.
- Single request:
  - Stimulus: Req=4'b0100, A slice2=8'd12, B slice2=8'd10, Ack=1.
  - Required: Gnt=4'b0100 for 1 cycle; next cycle Valid=1, Result=8'd120, ResultId=2; IDLE after.
- Truncation:
  - Stimulus: requester 0, a=8'd20, b=8'd20.
  - Required: Result=8'd144 (400 mod 256); with MUL_ARBITER_OVF_EN, Ovf=1.
  - Also: a=15, b=17 gives Result=255, Ovf=0.
- Round-robin:
  - Stimulus: Req=4'b1111 held, Ack=1 continuously, distinct operands per requester.
  - Required: ResultId sequence 0,1,2,3,0; each Result matches its own operands.
- Backpressure:
  - Stimulus: Ack=0 for 6 cycles after Valid rises, while Req=4'b0011 and operands change.
  - Required: Result/ResultId/Valid stable; no Gnt until Ack=1; the next grant goes to the other requester.
- Async reset mid-operation:
  - Stimulus: assert Rst=0 between clock edges in DONE.
  - Required: Valid and Busy drop at once, without a clock edge; after release, Req=4'b1111 grants requester 0 first.
